// File: rtl/corelet_seq_if.sv
// rtl/corelet_seq_if.sv - host start/config and corelet strobe bundle for the corelet tile sequencer
// master = sequencer side, slave = host/corelet side; CORELET_SEQ_PERF_EN adds the perf counters.
interface corelet_seq_if #(
   parameter int ADDR_W = 11,
   parameter int CNT_W  = 8
);
   logic              start;
   logic [CNT_W-1:0]  n_act;
   logic [ADDR_W-1:0] w_base;
   logic [ADDR_W-1:0] x_base;
   logic [ADDR_W-1:0] o_base;
   logic              mode_cfg;
   logic              data_mode_cfg;
   logic              l0_full;
   logic              ofifo_valid;
   logic              mem_cen;
   logic [ADDR_W-1:0] mem_addr;
   logic              l0_wr;
   logic              l0_rd;
   logic              load;
   logic              execute;
   logic              ofifo_rd;
   logic              mode;
   logic              data_mode;
   logic              psum_wen;
   logic [ADDR_W-1:0] psum_addr;
   logic              busy;
   logic              done;
   logic              err;
`ifdef CORELET_SEQ_PERF_EN
   logic [31:0]       perf_cycles;
   logic [15:0]       perf_stalls;
`endif

   modport master (
      input  start, n_act, w_base, x_base, o_base, mode_cfg, data_mode_cfg, l0_full, ofifo_valid,
      output mem_cen, mem_addr, l0_wr, l0_rd, load, execute, ofifo_rd, mode, data_mode,
             psum_wen, psum_addr, busy, done, err
`ifdef CORELET_SEQ_PERF_EN
      , output perf_cycles, perf_stalls
`endif
   );

   modport slave (
      output start, n_act, w_base, x_base, o_base, mode_cfg, data_mode_cfg, l0_full, ofifo_valid,
      input  mem_cen, mem_addr, l0_wr, l0_rd, load, execute, ofifo_rd, mode, data_mode,
             psum_wen, psum_addr, busy, done, err
`ifdef CORELET_SEQ_PERF_EN
      , input perf_cycles, perf_stalls
`endif
   );
endinterface

// File: rtl/corelet_seq.sv
// rtl/corelet_seq.sv - corelet tile sequencer: weight fill/load, activation fill, execute, OFIFO drain
// Optional CORELET_SEQ_PERF_EN adds saturating perf_cycles/perf_stalls counters.
module corelet_seq #(
   parameter int row    = 8,
   parameter int col    = 8,
   parameter int ADDR_W = 11,
   parameter int CNT_W  = 8
) (
   input  logic          clk,
   input  logic          reset,
   corelet_seq_if.master bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_W_FILL, S_W_LOAD, S_W_SETTLE, S_X_FILL, S_EXEC, S_O_READ, S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] W_LAST = CNT_W'(row - 1);
   localparam logic [CNT_W-1:0] L_LAST = CNT_W'(col - 1);
   localparam logic [CNT_W-1:0] S_LAST = CNT_W'(row + col - 1);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, wr_cnt_q, wr_cnt_d, n_act_q, n_act_d;
   logic [ADDR_W-1:0] w_base_q, w_base_d, x_base_q, x_base_d, o_base_q, o_base_d;
   logic              mode_q, mode_d, data_mode_q, data_mode_d;
   logic              mem_cen_q, mem_cen_d, l0_wr_q, l0_wr_d, l0_rd_q, l0_rd_d;
   logic              load_q, load_d, execute_q, execute_d, ofifo_rd_q, ofifo_rd_d;
   logic              psum_wen_q, psum_wen_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d, psum_addr_q, psum_addr_d;
   logic              accept;

   assign accept = (state_q == S_IDLE) && bus.start && (bus.n_act != '0);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wr_cnt_d    = wr_cnt_q;
      n_act_d     = n_act_q;
      w_base_d    = w_base_q;
      x_base_d    = x_base_q;
      o_base_d    = o_base_q;
      mode_d      = mode_q;
      data_mode_d = data_mode_q;
      mem_cen_d   = 1'b1;
      mem_addr_d  = mem_addr_q;
      l0_wr_d     = 1'b0;
      l0_rd_d     = 1'b0;
      load_d      = 1'b0;
      execute_d   = 1'b0;
      ofifo_rd_d  = 1'b0;
      err_d       = 1'b0;
      // every OFIFO read turns into a psum write on the following cycle
      psum_wen_d  = ofifo_rd_q;
      psum_addr_d = psum_addr_q;
      if (ofifo_rd_q) begin
         psum_addr_d = o_base_q + ADDR_W'(wr_cnt_q);
         wr_cnt_d    = wr_cnt_q + ONE;
      end

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               n_act_d     = bus.n_act;
               w_base_d    = bus.w_base;
               x_base_d    = bus.x_base;
               o_base_d    = bus.o_base;
               mode_d      = bus.mode_cfg;
               data_mode_d = bus.data_mode_cfg;
               cnt_d       = '0;
               wr_cnt_d    = '0;
               state_d     = S_W_FILL;
            end else if (bus.start) begin
               err_d = 1'b1;
            end
         end
         S_W_FILL: begin
            if (!bus.l0_full) begin
               mem_cen_d  = 1'b0;
               l0_wr_d    = 1'b1;
               mem_addr_d = w_base_q + ADDR_W'(cnt_q);
               cnt_d      = (cnt_q == W_LAST) ? '0 : cnt_q + ONE;
               if (cnt_q == W_LAST) state_d = S_W_LOAD;
            end
         end
         S_W_LOAD: begin
            l0_rd_d = 1'b1;
            load_d  = 1'b1;
            cnt_d   = (cnt_q == L_LAST) ? '0 : cnt_q + ONE;
            if (cnt_q == L_LAST) state_d = S_W_SETTLE;
         end
         S_W_SETTLE: begin
            cnt_d = (cnt_q == S_LAST) ? '0 : cnt_q + ONE;
            if (cnt_q == S_LAST) state_d = S_X_FILL;
         end
         S_X_FILL: begin
            if (!bus.l0_full) begin
               mem_cen_d  = 1'b0;
               l0_wr_d    = 1'b1;
               mem_addr_d = x_base_q + ADDR_W'(cnt_q);
               cnt_d      = (cnt_q == n_act_q - ONE) ? '0 : cnt_q + ONE;
               if (cnt_q == n_act_q - ONE) state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            l0_rd_d   = 1'b1;
            execute_d = 1'b1;
            cnt_d     = (cnt_q == n_act_q - ONE) ? '0 : cnt_q + ONE;
            if (cnt_q == n_act_q - ONE) state_d = S_O_READ;
         end
         S_O_READ: begin
            // cnt_q counts reads issued; leave only once the last read's write is out
            if (cnt_q != n_act_q) begin
               if (bus.ofifo_valid) begin
                  ofifo_rd_d = 1'b1;
                  cnt_d      = cnt_q + ONE;
               end
            end else if (!ofifo_rd_q) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         wr_cnt_q    <= '0;
         n_act_q     <= '0;
         w_base_q    <= '0;
         x_base_q    <= '0;
         o_base_q    <= '0;
         mode_q      <= 1'b0;
         data_mode_q <= 1'b0;
         mem_cen_q   <= 1'b1;
         mem_addr_q  <= '0;
         l0_wr_q     <= 1'b0;
         l0_rd_q     <= 1'b0;
         load_q      <= 1'b0;
         execute_q   <= 1'b0;
         ofifo_rd_q  <= 1'b0;
         psum_wen_q  <= 1'b0;
         psum_addr_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wr_cnt_q    <= wr_cnt_d;
         n_act_q     <= n_act_d;
         w_base_q    <= w_base_d;
         x_base_q    <= x_base_d;
         o_base_q    <= o_base_d;
         mode_q      <= mode_d;
         data_mode_q <= data_mode_d;
         mem_cen_q   <= mem_cen_d;
         mem_addr_q  <= mem_addr_d;
         l0_wr_q     <= l0_wr_d;
         l0_rd_q     <= l0_rd_d;
         load_q      <= load_d;
         execute_q   <= execute_d;
         ofifo_rd_q  <= ofifo_rd_d;
         psum_wen_q  <= psum_wen_d;
         psum_addr_q <= psum_addr_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign bus.mem_cen   = mem_cen_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.l0_wr     = l0_wr_q;
   assign bus.l0_rd     = l0_rd_q;
   assign bus.load      = load_q;
   assign bus.execute   = execute_q;
   assign bus.ofifo_rd  = ofifo_rd_q;
   assign bus.mode      = mode_q;
   assign bus.data_mode = data_mode_q;
   assign bus.psum_wen  = psum_wen_q;
   assign bus.psum_addr = psum_addr_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;

`ifdef CORELET_SEQ_PERF_EN
   logic [31:0] perf_cycles_q, perf_cycles_d;
   logic [15:0] perf_stalls_q, perf_stalls_d;

   // the accepting cycle counts as 1; every non-idle cycle up to and including DONE adds one
   always_comb begin
      perf_cycles_d = perf_cycles_q;
      perf_stalls_d = perf_stalls_q;
      if (accept) begin
         perf_cycles_d = 32'd1;
         perf_stalls_d = '0;
      end else begin
         if (state_q != S_IDLE && perf_cycles_q != '1) perf_cycles_d = perf_cycles_q + 32'd1;
         if ((state_q == S_W_FILL || state_q == S_X_FILL) && bus.l0_full && perf_stalls_q != '1)
            perf_stalls_d = perf_stalls_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_cycles_q <= '0;
         perf_stalls_q <= '0;
      end else begin
         perf_cycles_q <= perf_cycles_d;
         perf_stalls_q <= perf_stalls_d;
      end
   end

   assign bus.perf_cycles = perf_cycles_q;
   assign bus.perf_stalls = perf_stalls_q;
`endif
endmodule

// File: tb/tb_corelet_seq.sv
// tb/tb_corelet_seq.sv - scoreboard bench for corelet_seq (perf checks when CORELET_SEQ_PERF_EN is defined)
module tb_corelet_seq;
   localparam int ADDR_W = 11;
   localparam int CNT_W  = 8;
   localparam int ROW    = 8;
   localparam int COL    = 8;
   localparam int AMASK  = (1 << ADDR_W) - 1;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   corelet_seq_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();
   corelet_seq #(.row(ROW), .col(COL), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;
   int exp_mem_q[$];
   int exp_psum_q[$];
   int n_wbeat, n_xbeat, n_load, n_exec, n_quiet, n_xgap, n_ofrd, n_psum, n_errp, n_done, n_viol;
   int n_act_cur, done_cyc, start_cyc;
   bit prev_psum;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // observe one cycle of DUT outputs, popping the scoreboard on every write-type event
   task automatic sample();
      bit quiet;
      quiet = bus.mem_cen && !bus.l0_wr && !bus.l0_rd && !bus.load && !bus.execute &&
              !bus.ofifo_rd && !bus.psum_wen;
      if (!bus.mem_cen || bus.l0_wr) begin
         if (bus.mem_cen || !bus.l0_wr) n_viol++;
         if (n_load == 0) n_wbeat++; else n_xbeat++;
         if (exp_mem_q.size() == 0) check("mem_extra", 32'(bus.mem_addr), 32'hffff_ffff);
         else check("mem_addr", 32'(bus.mem_addr), exp_mem_q.pop_front());
      end
      if (bus.load) n_load++;
      if (bus.execute) n_exec++;
      if ((bus.load && bus.execute) || (bus.l0_wr && bus.l0_rd)) n_viol++;
      if (bus.ofifo_rd) begin
         n_ofrd++;
         if (!bus.ofifo_valid) n_viol++;
      end
      if (bus.psum_wen) begin
         n_psum++;
         if (exp_psum_q.size() == 0) check("psum_extra", 32'(bus.psum_addr), 32'hffff_ffff);
         else check("psum_addr", 32'(bus.psum_addr), exp_psum_q.pop_front());
      end
      if (bus.err) n_errp++;
      if (bus.done) begin
         n_done++;
         done_cyc = cyc;
         if (!prev_psum) n_viol++;
      end
      if (quiet && n_load > 0 && n_xbeat == 0) n_quiet++;
      if (quiet && n_xbeat > 0 && n_xbeat < n_act_cur) n_xgap++;
      prev_psum = bus.psum_wen;
   endtask

   task automatic run_tile(input int na, input int wb, input int xb, input int ob, input int x_stall,
                           input int of_mode, input bit restart, input bit md, input bit dmd);
      int  stall_left, post;
      bit  stall_started, restarted;
      exp_mem_q.delete();
      exp_psum_q.delete();
      n_wbeat = 0; n_xbeat = 0; n_load = 0; n_exec = 0; n_quiet = 0; n_xgap = 0;
      n_ofrd = 0; n_psum = 0; n_errp = 0; n_done = 0; n_viol = 0; prev_psum = 0;
      n_act_cur = na; done_cyc = 0;
      for (int i = 0; i < ROW; i++) exp_mem_q.push_back((wb + i) & AMASK);
      for (int i = 0; i < na; i++) exp_mem_q.push_back((xb + i) & AMASK);
      for (int i = 0; i < na; i++) exp_psum_q.push_back((ob + i) & AMASK);
      @(negedge clk); #1;
      bus.n_act = CNT_W'(na);
      bus.w_base = ADDR_W'(wb);
      bus.x_base = ADDR_W'(xb);
      bus.o_base = ADDR_W'(ob);
      bus.mode_cfg = md;
      bus.data_mode_cfg = dmd;
      bus.start = 1'b1;
      start_cyc = cyc;
      post = 0; stall_left = 0; stall_started = 0; restarted = 0;
      for (int c = 0; c < 6000 && post < 3; c++) begin
         @(negedge clk);
         sample();
         if (n_done > 0) post++;
         #1;
         bus.start = 1'b0;
         if (restart && !restarted && n_exec > 0) begin
            bus.start = 1'b1;
            bus.n_act = CNT_W'(7);
            bus.mode_cfg = !md;
            bus.data_mode_cfg = !dmd;
            restarted = 1;
         end
         if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) bus.l0_full = 1'b0;
         end else if (x_stall > 0 && !stall_started && n_xbeat == 2) begin
            bus.l0_full = 1'b1;
            stall_left = x_stall;
            stall_started = 1;
         end
         case (of_mode)
            0:       bus.ofifo_valid = 1'b1;
            1:       bus.ofifo_valid = (c % 3 == 0);
            default: bus.ofifo_valid = 1'($urandom_range(0, 1));
         endcase
      end
      check("done_count", n_done, 1);
      check("mem_left", exp_mem_q.size(), 0);
      check("psum_left", exp_psum_q.size(), 0);
      check("w_beats", n_wbeat, ROW);
      check("x_beats", n_xbeat, na);
      check("load_cycles", n_load, COL);
      check("exec_cycles", n_exec, na);
      check("settle_quiet", n_quiet, ROW + COL);
      check("x_stall_gap", n_xgap, x_stall);
      check("ofifo_reads", n_ofrd, na);
      check("psum_writes", n_psum, na);
      check("violations", n_viol, 0);
      check("err_in_tile", n_errp, 0);
      check("busy_after", bus.busy, 0);
      check("mode_held", bus.mode, md);
      check("data_mode_held", bus.data_mode, dmd);
      if (restart) check("restart_issued", restarted, 1);
`ifdef CORELET_SEQ_PERF_EN
      check("perf_cycles", bus.perf_cycles, done_cyc - start_cyc + 1);
      check("perf_stalls", 32'(bus.perf_stalls), x_stall);
`endif
   endtask

   initial begin
      bus.start = 0; bus.n_act = '0; bus.w_base = '0; bus.x_base = '0; bus.o_base = '0;
      bus.mode_cfg = 0; bus.data_mode_cfg = 0; bus.l0_full = 0; bus.ofifo_valid = 0;
      repeat (3) @(negedge clk);
      check("rst_mem_cen", bus.mem_cen, 1);
      check("rst_busy", bus.busy, 0);
      check("rst_strobes", {bus.l0_wr, bus.l0_rd, bus.load, bus.execute, bus.ofifo_rd, bus.psum_wen}, 0);
      check("rst_done_err", {bus.done, bus.err, bus.mode, bus.data_mode}, 0);
      #1 reset = 1'b1;

      // zero-length tile is rejected with a single err pulse
      @(negedge clk); #1;
      bus.n_act = '0; bus.start = 1'b1;
      @(negedge clk);
      check("rej_err", bus.err, 1);
      check("rej_busy", bus.busy, 0);
      #1 bus.start = 1'b0;
      @(negedge clk);
      check("rej_err_pulse", bus.err, 0);
      check("rej_busy2", bus.busy, 0);

      run_tile(4, 0, 16, 100, 0, 0, 0, 1, 0);
      run_tile(4, 0, 16, 100, 3, 0, 0, 0, 1);
      run_tile(5, 40, 200, 300, 0, 1, 0, 1, 1);
      run_tile(4, 8, 24, 500, 0, 0, 1, 1, 0);

      // async reset in the middle of W_LOAD
      @(negedge clk); #1;
      bus.n_act = CNT_W'(3); bus.w_base = '0; bus.start = 1'b1;
      @(negedge clk); #1 bus.start = 1'b0;
      for (int c = 0; c < 100 && !bus.load; c++) @(negedge clk);
      check("mrst_load_seen", bus.load, 1);
      check("mrst_busy_before", bus.busy, 1);
      #2 reset = 1'b0;
      #1;
      check("mrst_load", bus.load, 0);
      check("mrst_l0_rd", bus.l0_rd, 0);
      check("mrst_busy", bus.busy, 0);
      check("mrst_mem_cen", bus.mem_cen, 1);
`ifdef CORELET_SEQ_PERF_EN
      check("mrst_perf_cycles", bus.perf_cycles, 0);
`endif
      @(negedge clk); #1 reset = 1'b1;

      run_tile(3, 2046, 2045, 2046, 2, 1, 0, 0, 0);
      run_tile(255, 100, 1000, 1900, 5, 2, 0, 1, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
